// File: rtl/trace_uart_if.sv
// Trace capture and UART byte-stream signals between the core-side debug path and uart_tx.
// Handshake: a byte moves on every sys_clk edge where tx_data_valid and tx_data_ready are both 1; while
// valid is high and ready is low, tx_data is held stable; ready is ignored while valid is low.
interface trace_uart_if;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;
  logic        tx_data_ready;
  logic [7:0]  tx_data;
  logic        tx_data_valid;

  modport master (
    input  trace_valid,
    input  trace_pc,
    input  trace_instr,
    input  tx_data_ready,
    output tx_data,
    output tx_data_valid
  );

  modport slave (
    output trace_valid,
    output trace_pc,
    output trace_instr,
    output tx_data_ready,
    input  tx_data,
    input  tx_data_valid
  );
endinterface

// File: rtl/trace_uart_formatter.sv
// Buffers (PC, instruction) pairs in a small FIFO and streams each one to uart_tx as an
// ASCII line "PPPPPPPP IIIIIIII\r\n" over a valid/ready byte handshake.
module trace_uart_formatter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  trace_uart_if.master  bus,
  output logic [AW:0]   fifo_level,
  output logic [7:0]    drop_cnt,
  output logic          busy,
  output logic          fsm_state
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [4:0]  LAST_IDX = 5'd18;

  state_t        state;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [63:0]   frame;
  logic [4:0]    idx;
  logic          pop;
  logic          push;
  logic          xfer;
  logic [63:0]   head;

  // Map a line position to its ASCII character for the given {pc, instr} frame.
  function automatic logic [7:0] char_at(input logic [63:0] f, input logic [4:0] i);
    logic [31:0] word;
    logic [31:0] shifted;
    logic [2:0]  k;
    logic [3:0]  nib;
    logic [7:0]  c;
    word    = f[63:32];
    k       = i[2:0];
    if (i > 5'd8) begin
      word = f[31:0];
      k    = i[2:0] - 3'd1;
    end
    shifted = word << {k, 2'b00};
    nib     = shifted[31:28];
    if (nib < 4'd10) c = 8'h30 + {4'h0, nib};
    else             c = 8'h37 + {4'h0, nib};
    case (i)
      5'd8:    char_at = 8'h20;
      5'd17:   char_at = 8'h0D;
      5'd18:   char_at = 8'h0A;
      default: char_at = c;
    endcase
  endfunction

  assign head = mem[rd_ptr];
  assign pop  = (state == IDLE) && (fifo_level != '0);
  // A full FIFO still accepts a strobe when the head leaves in the same cycle.
  assign push = bus.trace_valid && ((fifo_level != FULL_LVL) || pop);
  assign xfer = (state == SEND) && bus.tx_data_valid && bus.tx_data_ready;

  assign busy      = (state != IDLE) || (fifo_level != '0);
  assign fsm_state = state;

  // Storage is left unreset; occupancy is governed entirely by the pointers and level.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= {bus.trace_pc, bus.trace_instr};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_cnt   <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (bus.trace_valid && !push && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'h01;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state             <= IDLE;
      frame             <= '0;
      idx               <= '0;
      bus.tx_data       <= 8'h00;
      bus.tx_data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.tx_data_valid <= 1'b0;
          if (pop) begin
            frame             <= head;
            idx               <= 5'd0;
            bus.tx_data       <= char_at(head, 5'd0);
            bus.tx_data_valid <= 1'b1;
            state             <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              bus.tx_data_valid <= 1'b0;
              bus.tx_data       <= 8'h00;
              state             <= IDLE;
            end else begin
              idx         <= idx + 5'd1;
              bus.tx_data <= char_at(frame, idx + 5'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_uart_formatter.sv
// Directed bench for trace_uart_formatter: expected line bytes are queued when strobes are driven
// and checked against every accepted byte on the UART side.
module tb_trace_uart_formatter;
  logic       sys_clk;
  logic       sys_rst;
  logic [2:0] fifo_level;
  logic [7:0] drop_cnt;
  logic       busy;
  logic       fsm_state;

  trace_uart_if bus ();

  trace_uart_formatter #(.DEPTH(4), .AW(2)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .bus        (bus.master),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];
  string hex_digits = "0123456789ABCDEF";

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent line model: table-driven hex digits.
  task automatic expect_frame(input logic [31:0] pc, input logic [31:0] instr);
    for (int i = 7; i >= 0; i--) exp_q.push_back(8'(hex_digits[(pc >> (4*i)) & 32'hF]));
    exp_q.push_back(8'h20);
    for (int i = 7; i >= 0; i--) exp_q.push_back(8'(hex_digits[(instr >> (4*i)) & 32'hF]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // scoreboard: every accepted byte is matched against the queue head
  always @(negedge sys_clk) begin
    logic [7:0] exp_b;
    if (!sys_rst && bus.tx_data_valid && bus.tx_data_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $error("FAIL unexpected_byte observed=%h expected=none", bus.tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        assert (bus.tx_data === exp_b) else begin
          bad++;
          $error("FAIL byte observed=%h expected=%h", bus.tx_data, exp_b);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] pc, input logic [31:0] instr);
    bus.trace_valid = 1'b1;
    bus.trace_pc    = pc;
    bus.trace_instr = instr;
    step();
    bus.trace_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.tx_data_valid && n < 50) begin
      step();
      n++;
    end
    check(tag, 32'(bus.tx_data_valid), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.tx_data_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      step();
      n++;
    end
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    bus.trace_valid   = 1'b0;
    bus.trace_pc      = '0;
    bus.trace_instr   = '0;
    bus.tx_data_ready = 1'b0;
    sys_rst           = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
    check("rst_valid", 32'(bus.tx_data_valid), 32'd0);
    check("rst_data", 32'(bus.tx_data), 32'h00);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);

    // single frame, ready held high: latency and 19 back-to-back transfers
    bus.tx_data_ready = 1'b1;
    expect_frame(32'h00000004, 32'h00500113);
    strobe(32'h00000004, 32'h00500113);
    check("lat_pop_cycle_valid", 32'(bus.tx_data_valid), 32'd0);
    step();
    check("lat_first_valid", 32'(bus.tx_data_valid), 32'd1);
    check("lat_first_byte", 32'(bus.tx_data), 32'h30);
    n = 0;
    while (bus.tx_data_valid && n < 100) begin
      step();
      n++;
    end
    check("frame_len", 32'(n), 32'd19);
    check("after_frame_valid", 32'(bus.tx_data_valid), 32'd0);
    drain("frame1");

    // hex letters
    expect_frame(32'hDEADBEEF, 32'hFFC4A303);
    strobe(32'hDEADBEEF, 32'hFFC4A303);
    step();
    check("hex_first_D", 32'(bus.tx_data), 32'h44);
    drain("hex");

    // backpressure at idx 3
    bus.tx_data_ready = 1'b0;
    expect_frame(32'h12305678, 32'h9ABCDEF0);
    strobe(32'h12305678, 32'h9ABCDEF0);
    wait_valid("bp_wait_valid");
    bus.tx_data_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.tx_data_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", 32'(bus.tx_data_valid), 32'd1);
      check("bp_hold_data", 32'(bus.tx_data), 32'h30);
      step();
    end
    drain("bp");

    // overflow: six strobes into a stalled block
    bus.tx_data_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) expect_frame(32'h1000_0000 + 32'(i), 32'hA000_0000 + 32'(i * 17));
      strobe(32'h1000_0000 + 32'(i), 32'hA000_0000 + 32'(i * 17));
    end
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_drop", 32'(drop_cnt), 32'd1);

    // saturation while full
    for (int i = 0; i < 300; i++) strobe(32'($urandom_range(0, 32'hFFFF)), 32'($urandom()));
    check("sat_drop", 32'(drop_cnt), 32'hFF);
    check("sat_level", 32'(fifo_level), 32'd4);
    drain("ovf");

    // reset mid-frame at idx 10 with an entry still queued
    bus.tx_data_ready = 1'b0;
    expect_frame(32'hCAFE0000, 32'h0000BABE);
    strobe(32'hCAFE0000, 32'h0000BABE);
    wait_valid("mid_wait_valid");
    strobe(32'h55555555, 32'h66666666);
    bus.tx_data_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.tx_data_ready = 1'b0;
    check("mid_level_before", 32'(fifo_level), 32'd1);
    sys_rst = 1'b1;
    exp_q.delete();
    step();
    sys_rst = 1'b0;
    check("mid_rst_valid", 32'(bus.tx_data_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    step();
    check("mid_rst_stays_idle", 32'(bus.tx_data_valid), 32'd0);
    bus.tx_data_ready = 1'b1;
    expect_frame(32'h0BAD_F00D, 32'h1234_ABCD);
    strobe(32'h0BAD_F00D, 32'h1234_ABCD);
    drain("post_rst");

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
